// File: rtl/ts_header_parser.sv
// ts_header_parser: MPEG-TS header field extraction with per-PID continuity check.
// Latency 1 cycle from header byte 3 to hdr_valid; no backpressure, byte_valid=0 stalls.
module ts_header_parser #(
  parameter int PKT_LEN  = 188,
  parameter int NUM_PIDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        sync_in,
  output logic        hdr_valid,
  output logic [12:0] pid,
  output logic        tei,
  output logic        pusi,
  output logic [1:0]  tsc,
  output logic [1:0]  afc,
  output logic [3:0]  cc,
  output logic        cc_error,
  output logic        short_pkt,
  output logic        locked,
  output logic [15:0] pkt_count
);

  localparam int         IW       = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;
  localparam logic [7:0] IDX_LAST = 8'(PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  typedef struct packed {
    logic        vld;
    logic [12:0] pid;
    logic [3:0]  last_cc;
    logic        dup;
  } cc_entry_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        commit, short_det, lock_set, lock_clr, cap1, cap2;

  logic        sh_tei, sh_pusi;
  logic [4:0]  sh_pid_hi;
  logic [7:0]  sh_pid_lo;

  logic [12:0] c_pid;
  logic [1:0]  c_tsc, c_afc;
  logic [3:0]  c_cc;

  cc_entry_t   tbl_q [NUM_PIDS];
  cc_entry_t   tbl_d [NUM_PIDS];
  cc_entry_t   entry;
  logic        hit, free, skip, err_d;
  logic [IW-1:0] hit_idx, free_idx;
  logic [3:0]  nxt_cc;

  // Byte 3 is still on byte_in at commit, so its fields come straight from the bus.
  assign c_pid = {sh_pid_hi, sh_pid_lo};
  assign c_tsc = byte_in[7:6];
  assign c_afc = byte_in[5:4];
  assign c_cc  = byte_in[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    commit    = 1'b0;
    short_det = 1'b0;
    lock_set  = 1'b0;
    lock_clr  = 1'b0;
    cap1      = 1'b0;
    cap2      = 1'b0;
    if (byte_valid) begin
      case (state_q)
        IDLE: begin
          if (sync_in) begin
            state_d  = HDR;
            idx_d    = 8'd1;
            lock_set = 1'b1;
          end else begin
            lock_clr = 1'b1;
          end
        end
        HDR, BODY: begin
          if (sync_in) begin
            // Early sync: abandon this packet and reframe on the new one.
            short_det = 1'b1;
            lock_set  = 1'b1;
            state_d   = HDR;
            idx_d     = 8'd1;
          end else if (state_q == HDR) begin
            idx_d = idx_q + 8'd1;
            case (idx_q)
              8'd1:    cap1 = 1'b1;
              8'd2:    cap2 = 1'b1;
              default: begin
                commit  = 1'b1;
                state_d = BODY;
              end
            endcase
          end else if (idx_q == IDX_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    tbl_d    = tbl_q;
    err_d    = 1'b0;
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    skip     = (c_pid == 13'h1FFF) || sh_tei || (c_afc == 2'b00);
    for (int i = 0; i < NUM_PIDS; i++) begin
      if (!hit && tbl_q[i].vld && (tbl_q[i].pid == c_pid)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
    for (int i = 0; i < NUM_PIDS; i++) begin
      if (!free && !tbl_q[i].vld) begin
        free     = 1'b1;
        free_idx = IW'(i);
      end
    end
    entry  = tbl_q[hit_idx];
    nxt_cc = entry.last_cc + 4'd1;
    if (commit && !skip) begin
      if (hit) begin
        if (c_afc[0]) begin
          if (c_cc == nxt_cc) begin
            entry.dup = 1'b0;
          end else if ((c_cc == entry.last_cc) && !entry.dup) begin
            entry.dup = 1'b1;
          end else begin
            err_d     = 1'b1;
            entry.dup = 1'b0;
          end
        end else if (c_cc != entry.last_cc) begin
          err_d = 1'b1;
        end
        entry.last_cc  = c_cc;
        tbl_d[hit_idx] = entry;
      end else if (free) begin
        tbl_d[free_idx] = '{vld: 1'b1, pid: c_pid, last_cc: c_cc, dup: 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_valid <= 1'b0;
      pid       <= '0;
      tei       <= 1'b0;
      pusi      <= 1'b0;
      tsc       <= '0;
      afc       <= '0;
      cc        <= '0;
      cc_error  <= 1'b0;
      short_pkt <= 1'b0;
      locked    <= 1'b0;
      pkt_count <= '0;
      sh_tei    <= 1'b0;
      sh_pusi   <= 1'b0;
      sh_pid_hi <= '0;
      sh_pid_lo <= '0;
      for (int i = 0; i < NUM_PIDS; i++) tbl_q[i] <= '0;
    end else begin
      hdr_valid <= commit;
      cc_error  <= commit & err_d;
      short_pkt <= short_det;
      if (lock_set)      locked <= 1'b1;
      else if (lock_clr) locked <= 1'b0;
      if (cap1) begin
        sh_tei    <= byte_in[7];
        sh_pusi   <= byte_in[6];
        sh_pid_hi <= byte_in[4:0];
      end
      if (cap2) sh_pid_lo <= byte_in;
      if (commit) begin
        pid       <= c_pid;
        tei       <= sh_tei;
        pusi      <= sh_pusi;
        tsc       <= c_tsc;
        afc       <= c_afc;
        cc        <= c_cc;
        pkt_count <= pkt_count + 16'd1;
      end
      tbl_q <= tbl_d;
    end
  end

endmodule
